// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
// Forward-select and FSM state encodings plus the per-stage control bundle.
package pipe_ctrl_pkg;

    localparam int RFIDX_WIDTH = 5;
    localparam int CNT_W       = 32;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic mem_wb_en;
    } stage_ctl_t;

    localparam stage_ctl_t CTL_NONE = '{
        pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
        id_ex_en: 1'b0, id_ex_flush: 1'b0,
        ex_mem_en: 1'b0, mem_wb_en: 1'b0
    };

endpackage

// File: rtl/fwd_unit.sv
// EX operand forwarding compare for one source register.
// Ports: rs_index, MEM rd/write, WB rd/write in; 2-bit select out.
module fwd_unit #(
    parameter int RFIDX_WIDTH = pipe_ctrl_pkg::RFIDX_WIDTH
) (
    input  logic [RFIDX_WIDTH-1:0] rs_index,
    input  logic [RFIDX_WIDTH-1:0] mem_rd_index,
    input  logic                   mem_reg_write,
    input  logic [RFIDX_WIDTH-1:0] wb_rd_index,
    input  logic                   wb_reg_write,
    output logic [1:0]             sel
);
    import pipe_ctrl_pkg::*;

    logic mem_hit;
    logic wb_hit;

    // x0 is hardwired zero, so a write to it never forwards
    assign mem_hit = mem_reg_write && (mem_rd_index != '0)
                     && (mem_rd_index == rs_index);
    assign wb_hit  = wb_reg_write && (wb_rd_index != '0)
                     && (wb_rd_index == rs_index);

    // Both can hit; the younger EX/MEM result wins
    always_comb begin
        sel = FWD_RF;
        priority case (1'b1)
            mem_hit: sel = FWD_EXMEM;
            wb_hit:  sel = FWD_MEMWB;
            default: sel = FWD_RF;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline registers.
// Ports: ID/EX/MEM/WB reg indices and control bits, branch and dmem
// handshake in; stage enables/flushes, forward selects, perf counters out.
module pipe_ctrl #(
    parameter int RFIDX_WIDTH = pipe_ctrl_pkg::RFIDX_WIDTH,
    parameter int CNT_W       = pipe_ctrl_pkg::CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [RFIDX_WIDTH-1:0] id_rs1_index,
    input  logic [RFIDX_WIDTH-1:0] id_rs2_index,
    input  logic                   id_rs1_used,
    input  logic                   id_rs2_used,
    input  logic [RFIDX_WIDTH-1:0] ex_rs1_index,
    input  logic [RFIDX_WIDTH-1:0] ex_rs2_index,
    input  logic [RFIDX_WIDTH-1:0] ex_rd_index,
    input  logic                   ex_mem_read,
    input  logic [RFIDX_WIDTH-1:0] mem_rd_index,
    input  logic                   mem_reg_write,
    input  logic [RFIDX_WIDTH-1:0] wb_rd_index,
    input  logic                   wb_reg_write,
    input  logic                   ex_branch_taken,
    input  logic                   dmem_req,
    input  logic                   dmem_ready,
    output logic                   pc_en,
    output logic                   if_id_en,
    output logic                   if_id_flush,
    output logic                   id_ex_en,
    output logic                   id_ex_flush,
    output logic                   ex_mem_en,
    output logic                   mem_wb_en,
    output logic [1:0]             fwd_a_sel,
    output logic [1:0]             fwd_b_sel,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       flush_cnt
);
    import pipe_ctrl_pkg::*;

    state_e     state;
    stage_ctl_t ctl;

    logic active;
    logic freeze;
    logic ld_hazard;
    logic branch_go;
    logic load_use;
    logic stall_inc;
    logic flush_inc;

    assign active = (state != HOLD);

    assign freeze = active && dmem_req && !dmem_ready;

    assign ld_hazard = ex_mem_read && (ex_rd_index != '0)
        && ((id_rs1_used && (id_rs1_index == ex_rd_index))
         || (id_rs2_used && (id_rs2_index == ex_rd_index)));

    // A branch seen during a freeze is simply not acted on; EX holds it,
    // so it is taken on the release cycle with no extra state.
    assign branch_go = active && !freeze && ex_branch_taken;
    assign load_use  = active && !freeze && !ex_branch_taken && ld_hazard;

    assign stall_inc = freeze || load_use;
    assign flush_inc = branch_go;

    always_comb begin
        ctl = CTL_NONE;
        priority case (1'b1)
            !active: begin
                ctl.if_id_flush = 1'b1;
                ctl.id_ex_flush = 1'b1;
            end
            freeze: begin
                ctl = CTL_NONE;
            end
            branch_go: begin
                ctl.pc_en       = 1'b1;
                ctl.if_id_en    = 1'b1;
                ctl.if_id_flush = 1'b1;
                ctl.id_ex_en    = 1'b1;
                ctl.id_ex_flush = 1'b1;
                ctl.ex_mem_en   = 1'b1;
                ctl.mem_wb_en   = 1'b1;
            end
            load_use: begin
                // ID/EX loads a bubble while the load moves on to MEM
                ctl.id_ex_en    = 1'b1;
                ctl.id_ex_flush = 1'b1;
                ctl.ex_mem_en   = 1'b1;
                ctl.mem_wb_en   = 1'b1;
            end
            default: begin
                ctl.pc_en     = 1'b1;
                ctl.if_id_en  = 1'b1;
                ctl.id_ex_en  = 1'b1;
                ctl.ex_mem_en = 1'b1;
                ctl.mem_wb_en = 1'b1;
            end
        endcase
    end

    assign pc_en       = ctl.pc_en;
    assign if_id_en    = ctl.if_id_en;
    assign if_id_flush = ctl.if_id_flush;
    assign id_ex_en    = ctl.id_ex_en;
    assign id_ex_flush = ctl.id_ex_flush;
    assign ex_mem_en   = ctl.ex_mem_en;
    assign mem_wb_en   = ctl.mem_wb_en;

    // Dropping dmem_req in MEM_WAIT clears freeze too, so it releases
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HOLD;
        end else begin
            case (state)
                HOLD:     state <= RUN;
                RUN:      if (freeze) state <= MEM_WAIT;
                MEM_WAIT: if (!freeze) state <= RUN;
                default:  state <= HOLD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    fwd_unit #(
        .RFIDX_WIDTH(RFIDX_WIDTH)
    ) u_fwd_a (
        .rs_index      (ex_rs1_index),
        .mem_rd_index  (mem_rd_index),
        .mem_reg_write (mem_reg_write),
        .wb_rd_index   (wb_rd_index),
        .wb_reg_write  (wb_reg_write),
        .sel           (fwd_a_sel)
    );

    fwd_unit #(
        .RFIDX_WIDTH(RFIDX_WIDTH)
    ) u_fwd_b (
        .rs_index      (ex_rs2_index),
        .mem_rd_index  (mem_rd_index),
        .mem_reg_write (mem_reg_write),
        .wb_rd_index   (wb_rd_index),
        .wb_reg_write  (wb_reg_write),
        .sel           (fwd_b_sel)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: reset, load-use, forwarding, dmem wait,
// deferred branch flush, branch vs load-use and 2-bit counter saturation.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs1_index, id_rs2_index;
    logic       id_rs1_used, id_rs2_used;
    logic [4:0] ex_rs1_index, ex_rs2_index, ex_rd_index;
    logic       ex_mem_read;
    logic [4:0] mem_rd_index, wb_rd_index;
    logic       mem_reg_write, wb_reg_write;
    logic       ex_branch_taken, dmem_req, dmem_ready;

    logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic        ex_mem_en, mem_wb_en;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [31:0] stall_cnt, flush_cnt;

    logic        s2_pc_en, s2_if_id_en, s2_if_id_flush, s2_id_ex_en;
    logic        s2_id_ex_flush, s2_ex_mem_en, s2_mem_wb_en;
    logic [1:0]  s2_fwd_a_sel, s2_fwd_b_sel;
    logic [1:0]  s2_stall_cnt, s2_flush_cnt;

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_index(id_rs1_index), .id_rs2_index(id_rs2_index),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rs1_index(ex_rs1_index), .ex_rs2_index(ex_rs2_index),
        .ex_rd_index(ex_rd_index), .ex_mem_read(ex_mem_read),
        .mem_rd_index(mem_rd_index), .mem_reg_write(mem_reg_write),
        .wb_rd_index(wb_rd_index), .wb_reg_write(wb_reg_write),
        .ex_branch_taken(ex_branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_index(id_rs1_index), .id_rs2_index(id_rs2_index),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rs1_index(ex_rs1_index), .ex_rs2_index(ex_rs2_index),
        .ex_rd_index(ex_rd_index), .ex_mem_read(ex_mem_read),
        .mem_rd_index(mem_rd_index), .mem_reg_write(mem_reg_write),
        .wb_rd_index(wb_rd_index), .wb_reg_write(wb_reg_write),
        .ex_branch_taken(ex_branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(s2_pc_en), .if_id_en(s2_if_id_en),
        .if_id_flush(s2_if_id_flush),
        .id_ex_en(s2_id_ex_en), .id_ex_flush(s2_id_ex_flush),
        .ex_mem_en(s2_ex_mem_en), .mem_wb_en(s2_mem_wb_en),
        .fwd_a_sel(s2_fwd_a_sel), .fwd_b_sel(s2_fwd_b_sel),
        .stall_cnt(s2_stall_cnt), .flush_cnt(s2_flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_rs1_index = '0; id_rs2_index = '0;
        id_rs1_used = 0; id_rs2_used = 0;
        ex_rs1_index = '0; ex_rs2_index = '0; ex_rd_index = '0;
        ex_mem_read = 0;
        mem_rd_index = '0; wb_rd_index = '0;
        mem_reg_write = 0; wb_reg_write = 0;
        ex_branch_taken = 0; dmem_req = 0; dmem_ready = 0;
    endtask

    task automatic set_lu();
        ex_mem_read = 1; ex_rd_index = 5;
        id_rs2_used = 1; id_rs2_index = 5;
    endtask

    initial begin
        clr();
        rst_n = 0;

        // reset
        @(negedge clk);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_flush", flush_cnt, 0);
        chk("rst_pc", 32'(pc_en), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("hold_pc", 32'(pc_en), 0);
        chk("hold_ifid_en", 32'(if_id_en), 0);
        chk("hold_ifid_fl", 32'(if_id_flush), 1);
        chk("hold_idex_fl", 32'(id_ex_flush), 1);
        nxt();
        @(negedge clk);
        chk("run_pc", 32'(pc_en), 1);
        chk("run_ifid_en", 32'(if_id_en), 1);
        chk("run_memwb_en", 32'(mem_wb_en), 1);
        chk("run_ifid_fl", 32'(if_id_flush), 0);
        chk("run_stall", stall_cnt, 0);

        // load-use: one bubble
        nxt();
        set_lu();
        @(negedge clk);
        chk("lu_pc", 32'(pc_en), 0);
        chk("lu_ifid_en", 32'(if_id_en), 0);
        chk("lu_idex_fl", 32'(id_ex_flush), 1);
        chk("lu_exmem_en", 32'(ex_mem_en), 1);
        nxt();
        ex_mem_read = 0;
        @(negedge clk);
        chk("lu_cnt", stall_cnt, 1);
        chk("lu_after_pc", 32'(pc_en), 1);
        chk("lu_after_fl", 32'(id_ex_flush), 0);
        nxt();
        ex_mem_read = 1; ex_rd_index = 0; id_rs2_index = 0;
        @(negedge clk);
        chk("lu_x0_pc", 32'(pc_en), 1);
        nxt();
        clr();
        @(negedge clk);
        chk("lu_x0_cnt", stall_cnt, 1);

        // forwarding
        ex_rs1_index = 3; ex_rs2_index = 7;
        mem_rd_index = 3; mem_reg_write = 1;
        wb_rd_index = 3; wb_reg_write = 1;
        #1;
        chk("fwd_a_mem", 32'(fwd_a_sel), 1);
        chk("fwd_b_none", 32'(fwd_b_sel), 0);
        mem_reg_write = 0;
        #1;
        chk("fwd_a_wb", 32'(fwd_a_sel), 2);
        ex_rs2_index = 3; mem_reg_write = 1;
        #1;
        chk("fwd_b_mem", 32'(fwd_b_sel), 1);
        ex_rs1_index = 0; mem_rd_index = 0; wb_rd_index = 0;
        #1;
        chk("fwd_a_x0", 32'(fwd_a_sel), 0);

        // dmem wait 4 cycles then ready
        nxt();
        clr();
        dmem_req = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mw_pc", 32'(pc_en), 0);
            chk("mw_exmem_en", 32'(ex_mem_en), 0);
            chk("mw_ifid_fl", 32'(if_id_flush), 0);
            nxt();
        end
        chk("mw_state", 32'(dut.state), 32'(MEM_WAIT));
        chk("mw_cnt", stall_cnt, 5); // 1 load-use + 4 freeze
        dmem_ready = 1;
        @(negedge clk);
        chk("mw_rel_pc", 32'(pc_en), 1);
        chk("mw_rel_memwb", 32'(mem_wb_en), 1);
        nxt();
        clr();
        @(negedge clk);
        chk("mw_run", 32'(dut.state), 32'(RUN));
        chk("mw_cnt2", stall_cnt, 5);

        // branch held during 2-cycle freeze
        nxt();
        dmem_req = 1; ex_branch_taken = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("bf_ifid_fl", 32'(if_id_flush), 0);
            chk("bf_idex_fl", 32'(id_ex_flush), 0);
            chk("bf_pc", 32'(pc_en), 0);
            nxt();
        end
        dmem_ready = 1;
        @(negedge clk);
        chk("bf_rel_pc", 32'(pc_en), 1);
        chk("bf_rel_ifid", 32'(if_id_flush), 1);
        chk("bf_rel_idex", 32'(id_ex_flush), 1);
        chk("bf_rel_cnt", flush_cnt, 0);
        nxt();
        clr();
        @(negedge clk);
        chk("bf_flush_cnt", flush_cnt, 1);
        chk("bf_stall_cnt", stall_cnt, 7);

        // branch beats load-use
        nxt();
        set_lu();
        ex_branch_taken = 1;
        @(negedge clk);
        chk("bl_pc", 32'(pc_en), 1);
        chk("bl_idex_fl", 32'(id_ex_flush), 1);
        chk("bl_ifid_fl", 32'(if_id_flush), 1);
        chk("bl_ifid_en", 32'(if_id_en), 1);
        nxt();
        clr();
        @(negedge clk);
        chk("bl_flush_cnt", flush_cnt, 2);
        chk("bl_stall_cnt", stall_cnt, 7);

        // async reset in mid-freeze
        nxt();
        dmem_req = 1;
        nxt();
        #2 rst_n = 0;
        #1;
        chk("ar_stall", stall_cnt, 0);
        chk("ar_flush", flush_cnt, 0);
        chk("ar_s2_stall", 32'(s2_stall_cnt), 0);
        chk("ar_state", 32'(dut.state), 32'(HOLD));
        nxt();
        nxt();
        clr();
        rst_n = 1;
        nxt();

        // saturation on the 2-bit instance
        set_lu();
        for (int i = 1; i <= 5; i++) begin
            nxt();
            chk("sat2", 32'(s2_stall_cnt), (i < 3) ? i : 3);
        end
        chk("sat32", stall_cnt, 5);
        clr();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
